// File: rtl/elelock_ctrl.sv
// Electronic lock code-entry sequencer: edge-detected ten-key entry,
// code compare, failed-attempt lockout and timed automatic relock.
module elelock_ctrl #(
  parameter int                  DIGITS      = 4,
  parameter logic [DIGITS*4-1:0] SECRET      = 16'h3707,
  parameter int                  MAX_TRIES   = 3,
  parameter int                  LOCKOUT_CYC = 1000,
  parameter int                  OPEN_CYC    = 5000,
  parameter int                  ENTRY_CYC   = 2000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] tenkey,
  input  logic       close,
  output logic       lock,
  output logic       error,
  output logic       lockout,
  output logic [3:0] digits
);

  localparam int BW = DIGITS * 4;
  localparam int OW = $clog2(OPEN_CYC + 1);
  localparam int LW = $clog2(LOCKOUT_CYC + 1);
  localparam int EW = $clog2(ENTRY_CYC + 1);
  localparam logic [OW-1:0] OPEN_LAST = OW'(OPEN_CYC - 1);
  localparam logic [LW-1:0] LOUT_LAST = LW'(LOCKOUT_CYC - 1);
  localparam logic [EW-1:0] ENT_LAST  = EW'(ENTRY_CYC - 1);
  localparam logic [3:0]    LAST_DIG  = 4'(DIGITS - 1);
  localparam logic [3:0]    TRY_LIM   = 4'(MAX_TRIES);

  typedef enum logic [1:0] {
    S_LOCKED,
    S_OPEN,
    S_LOCKOUT
  } state_t;

  state_t        state, state_nx;
  logic [9:0]    tenkey_q;
  logic [BW-5:0] code_buf;
  logic [3:0]    tries;
  logic [3:0]    tries_inc;
  logic [OW-1:0] open_t;
  logic [LW-1:0] lout_t;
  logic [EW-1:0] ent_t;
  logic [3:0]    key;
  logic [BW-1:0] full;
  logic          press;
  logic          last;
  logic          match;

  always_comb begin
    key = '0;
    for (int i = 0; i < 10; i++)
      if (tenkey[i]) key = 4'(i);
  end

  // a press needs a single key and an all-zero previous sample
  assign press = (tenkey_q == '0) && (tenkey != '0)
              && ((tenkey & (tenkey - 10'd1)) == '0);
  assign full      = {code_buf, key};
  assign last      = press && (digits == LAST_DIG);
  assign match     = last && (full == SECRET);
  assign tries_inc = (tries == 4'hF) ? tries : tries + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_LOCKED;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_LOCKED: begin
        if (!close && match)
          state_nx = S_OPEN;
        else if (!close && last && tries_inc == TRY_LIM)
          state_nx = S_LOCKOUT;
      end
      S_OPEN: begin
        if (close || open_t == OPEN_LAST)
          state_nx = S_LOCKED;
      end
      S_LOCKOUT: begin
        if (lout_t == LOUT_LAST)
          state_nx = S_LOCKED;
      end
      default: state_nx = S_LOCKED;
    endcase
  end

  always_comb begin
    lock    = (state != S_OPEN);
    lockout = (state == S_LOCKOUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tenkey_q <= '0;
      code_buf <= '0;
      digits   <= '0;
      tries    <= '0;
      error    <= 1'b0;
      open_t   <= '0;
      lout_t   <= '0;
      ent_t    <= '0;
    end else begin
      tenkey_q <= tenkey;
      error    <= 1'b0;
      unique case (state)
        S_LOCKED: begin
          open_t <= '0;
          lout_t <= '0;
          if (close) begin
            code_buf <= '0;
            digits   <= '0;
            ent_t    <= '0;
          end else if (press) begin
            ent_t <= '0;
            if (last) begin
              code_buf <= '0;
              digits   <= '0;
              if (match) begin
                tries <= '0;
              end else begin
                tries <= tries_inc;
                error <= 1'b1;
              end
            end else begin
              code_buf <= full[BW-5:0];
              digits   <= digits + 4'd1;
            end
          end else if (digits != '0) begin
            // partial entry abandoned: discard without counting a try
            if (ent_t == ENT_LAST) begin
              code_buf <= '0;
              digits   <= '0;
              ent_t    <= '0;
            end else begin
              ent_t <= ent_t + 1'b1;
            end
          end else begin
            ent_t <= '0;
          end
        end
        S_OPEN: begin
          if (state_nx != S_OPEN) open_t <= '0;
          else                    open_t <= open_t + 1'b1;
        end
        S_LOCKOUT: begin
          if (state_nx != S_LOCKOUT) begin
            lout_t <= '0;
            tries  <= '0;
          end else begin
            lout_t <= lout_t + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_elelock_ctrl.sv
// Directed bench for elelock_ctrl: entry, open window, lockout,
// press filtering, entry timeout, close priority and async reset.
module tb_elelock_ctrl;

  localparam int LOCKOUT_CYC = 1000;
  localparam int OPEN_CYC    = 5000;
  localparam int ENTRY_CYC   = 2000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] tenkey = '0;
  logic       close = 1'b0;
  logic       lock;
  logic       error;
  logic       lockout;
  logic [3:0] digits;

  int nchk = 0;
  int nerr = 0;

  elelock_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tenkey  (tenkey),
    .close   (close),
    .lock    (lock),
    .error   (error),
    .lockout (lockout),
    .digits  (digits)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] oh(input int d);
    logic [9:0] v;
    v = 10'd1;
    return v << d;
  endfunction

  task automatic step(input logic [9:0] k);
    tenkey = k;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0);
  endtask

  task automatic press(input int d);
    step(oh(d));
    step(oh(d));
    step('0);
  endtask

  task automatic wrong_code(input string tag);
    press(1);
    press(2);
    press(3);
    step(oh(4));
    check({tag, "_err1"}, 16'(error), 16'd1);
    step(oh(4));
    check({tag, "_err0"}, 16'(error), 16'd0);
    step('0);
  endtask

  task automatic open_code();
    press(3);
    press(7);
    press(0);
    step(oh(7));
    check("open_lock", 16'(lock), 16'd0);
    step(oh(7));
    step('0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_lock", 16'(lock), 16'd1);
    check("rst_err", 16'(error), 16'd0);
    check("rst_lout", 16'(lockout), 16'd0);
    check("rst_dig", 16'(digits), 16'd0);
    rst_n = 1'b1;

    // 3707 opens; then auto relock after OPEN_CYC
    press(3);
    check("dig1", 16'(digits), 16'd1);
    press(7);
    check("dig2", 16'(digits), 16'd2);
    press(0);
    check("dig3", 16'(digits), 16'd3);
    step(oh(7));
    check("open1_lock", 16'(lock), 16'd0);
    check("open1_err", 16'(error), 16'd0);
    check("open1_dig", 16'(digits), 16'd0);
    step(oh(7));
    step('0);
    idle(OPEN_CYC - 3);
    check("auto_pre", 16'(lock), 16'd0);
    step('0);
    check("auto_relock", 16'(lock), 16'd1);

    // close at cycle 10 of OPEN
    open_code();
    idle(7);
    check("close_pre", 16'(lock), 16'd0);
    close = 1'b1;
    step('0);
    close = 1'b0;
    check("close_relock", 16'(lock), 16'd1);

    // three wrong codes -> lockout
    wrong_code("w1");
    check("w1_lout", 16'(lockout), 16'd0);
    wrong_code("w2");
    check("w2_lout", 16'(lockout), 16'd0);
    press(1);
    press(2);
    press(3);
    step(oh(4));
    check("w3_err", 16'(error), 16'd1);
    check("w3_lout", 16'(lockout), 16'd1);
    step(oh(4));
    step('0);
    press(3);
    press(7);
    press(0);
    press(7);
    check("lo_lock", 16'(lock), 16'd1);
    check("lo_dig", 16'(digits), 16'd0);
    idle(LOCKOUT_CYC - 15);
    check("lo_pre", 16'(lockout), 16'd1);
    step('0);
    check("lo_end", 16'(lockout), 16'd0);
    check("lo_end_lock", 16'(lock), 16'd1);
    open_code();
    close = 1'b1;
    step('0);
    close = 1'b0;
    check("lo_relock", 16'(lock), 16'd1);

    // press filtering
    for (int i = 0; i < 20; i++) step(oh(3));
    check("hold_dig", 16'(digits), 16'd1);
    step('0);
    step(10'b0000001001);
    step('0);
    check("multi_dig", 16'(digits), 16'd1);
    step(oh(3));
    check("chg_dig3", 16'(digits), 16'd2);
    step(oh(7));
    check("chg_dig7", 16'(digits), 16'd2);
    step('0);
    close = 1'b1;
    step('0);
    close = 1'b0;
    check("close_clr", 16'(digits), 16'd0);

    // timeout does not count as a try (tries 1 -> 2, no lockout)
    wrong_code("t1");
    press(3);
    press(7);
    idle(ENTRY_CYC - 3);
    check("to_pre", 16'(digits), 16'd2);
    step('0);
    check("to_clr", 16'(digits), 16'd0);
    wrong_code("t2");
    check("to_lout", 16'(lockout), 16'd0);

    // close with the final digit: no compare, tries stay at 2
    press(3);
    press(7);
    press(0);
    close = 1'b1;
    step(oh(7));
    close = 1'b0;
    check("cp_dig", 16'(digits), 16'd0);
    check("cp_lock", 16'(lock), 16'd1);
    check("cp_err", 16'(error), 16'd0);
    step(oh(7));
    step('0);
    wrong_code("t3");
    check("cp_lout", 16'(lockout), 16'd1);
    idle(LOCKOUT_CYC);
    check("cp_lout_end", 16'(lockout), 16'd0);

    // asynchronous reset mid-entry
    press(3);
    press(7);
    press(0);
    check("ar_pre", 16'(digits), 16'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_dig", 16'(digits), 16'd0);
    check("ar_lock", 16'(lock), 16'd1);
    #1;
    rst_n = 1'b1;
    step('0);
    open_code();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/elelock_ctrl.md
# elelock_ctrl

Code-entry sequencer for the electronic lock. It takes raw one-hot ten-key input and edge-detects key presses. It collects a DIGITS-long code, compares it against SECRET, and drives the lock bolt. It also counts failed attempts into a timed lockout and automatically relocks after a fixed open window or on the close button.

## Interface
- DIGITS, 4: code length in decimal digits (2..8).
- SECRET, 16'h3707: expected code, 4-bit BCD per digit, first-entered digit in the most significant nibble; width DIGITS*4.
- MAX_TRIES, 3: consecutive failed codes that trigger lockout (1..15).
- LOCKOUT_CYC, 1000: lockout duration in clk cycles.
- OPEN_CYC, 5000: unlocked window before automatic relock, in clk cycles.
- ENTRY_CYC, 2000: idle cycles allowed between digits before a partial entry is discarded.
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- tenkey  input  10  one-hot key switches; bit i = digit i.
- close  input  1  close/relock request, level-sampled.
- lock  output  1  1 = bolt engaged.
- error  output  1  one-cycle pulse on a wrong complete code.
- lockout  output  1  1 while in LOCKOUT.
- digits  output  4  number of digits held in the entry buffer.

## Operation
- Reset (async, rst_n=0) gives: state LOCKED, lock=1, error=0, lockout=0, digits=0, tries=0, buffer=0, all timers=0, tenkey_q=0.
- Press detection: tenkey_q registers tenkey every cycle. A press is accepted at an edge when tenkey has exactly one bit set and tenkey_q==0. Keys held over several cycles, multi-bit values, and changes without an intervening all-zero cycle are ignored. The digit is encoded as the index of the set bit.
- LOCKED: lock=1.
  - On a press with digits<DIGITS-1, shift the digit into the buffer, increment digits, and clear the entry timer.
  - On a press with digits==DIGITS-1, compare {buffer, digit} with SECRET at the same edge.
    - Match: go to OPEN, set tries=0, clear the buffer, set digits=0.
    - Mismatch: error=1 for one cycle, tries+1, clear the buffer, set digits=0. If tries+1==MAX_TRIES, go to LOCKOUT.
  - close=1 clears the buffer and sets digits=0.
  - Entry timeout: while digits>0, count idle cycles. When the count reaches ENTRY_CYC, clear the buffer and set digits=0. A timeout does not count as a failed attempt.
- OPEN: lock=0. Presses are ignored. The open timer counts up. Return to LOCKED with lock=1 when close=1 or when the timer reaches OPEN_CYC.
- LOCKOUT: lockout=1, lock=1. Presses and close are ignored. After LOCKOUT_CYC cycles, go to LOCKED with tries=0 and lockout=0.
- Simultaneous events:
  - close and a press at the same edge in LOCKED: close wins. The buffer is cleared, no compare is made, and tries is unchanged.
  - Timeout and a press at the same edge: the press wins and the timer restarts.
  - close at the OPEN_CYC expiry edge: a single relock.
- Counters saturate and never wrap. tries is 4 bits. Timers are sized to their parameter.

## Timing
- Registered outputs all update on the edge that samples the event.
- Final correct digit present on tenkey before edge k (tenkey_q==0): lock=0 after edge k.
- Wrong final digit: error=1 for the cycle after edge k only.
- OPEN entered at edge k: lock returns to 1 after edge k+OPEN_CYC if close is never asserted.
- close sampled 1 at edge k in OPEN: lock=1 after edge k.
- LOCKOUT entered at edge k: lockout=0 after edge k+LOCKOUT_CYC.
- rst_n asserted mid-entry, in OPEN, or in LOCKOUT forces the reset values immediately, without waiting for clk.

## Test plan
- Reset then press 3,7,0,7, each held 2 cycles with 1 zero cycle between -> digits steps 1,2,3, and lock=0 the cycle after the final 7 is accepted; error stays 0.
- Correct code, then idle OPEN_CYC cycles -> lock=1 exactly OPEN_CYC cycles after opening. Repeat with close pulsed at cycle 10 of OPEN -> lock=1 after that edge.
- Enter 1,2,3,4 three times -> error pulses 3 times and lockout=1 after the third. Entering 3707 during lockout leaves lock=1. lockout=0 after LOCKOUT_CYC, then 3707 opens.
- Hold 3 for 20 cycles -> digits=1 only. Apply 10'b0000001001 -> ignored. Apply 3 then 7 with no zero cycle between -> 7 ignored.
- Enter 3,7 then idle ENTRY_CYC cycles -> digits=0, tries unchanged. Enter 3,7,0, then assert close together with the final 7 -> digits=0, lock=1, no error.
- Enter 3,7,0, assert rst_n=0 between edges -> digits=0 and lock=1 asynchronously. After release, 3707 opens.
